// File: rtl/ic_7400.sv
// Quad 2-input NAND (7400) for the 74xxx board-level library.
// Combinational by default; optionally registered on clk with synchronous reset.
module ic_7400 #(
  parameter bit         REGISTERED  = 1'b0,
  parameter int         TPD         = 0,
  parameter logic [3:0] RESET_VALUE = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  logic [3:0] nand_y;
  logic [3:0] y_int;

  // Per-bit NAND keeps the usual 4-state rule: a 0 on either input forces 1.
  for (genvar i = 0; i < 4; i++) begin : g_gate
    assign nand_y[i] = ~(a[i] & b[i]);
  end

  if (REGISTERED) begin : g_reg
    logic [3:0] y_q;

    always_ff @(posedge clk) begin
      if (rst) y_q <= RESET_VALUE;
      else     y_q <= nand_y;
    end

    assign y_int = y_q;
  end else begin : g_comb
    // clk and rst have no function in the combinational part.
    logic unused;
    assign unused = clk ^ rst;
    assign y_int  = nand_y;
  end

  // Simulation-only propagation delay; synthesis ignores it.
  if (TPD == 0) begin : g_nodly
    assign y = y_int;
  end else begin : g_dly
    assign #(TPD) y = y_int;
  end

endmodule

// File: tb/tb_ic_7400.sv
// Self-checking bench for ic_7400: combinational, delayed and registered
// instances checked against a truth-table reference model.
module tb_ic_7400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a_c = '0, b_c = '0;
  logic [3:0] a_d = '0, b_d = '0;
  logic [3:0] a_r = '0, b_r = '0;
  logic [3:0] y_c, y_d, y_r;

  int total  = 0;
  int passed = 0;

  // One gate's truth table indexed by {a,b}: 00,01,10 -> 1, 11 -> 0.
  bit tt [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  ic_7400 #(.REGISTERED(1'b0), .TPD(0)) dut_c (
    .clk(clk), .rst(rst), .a(a_c), .b(b_c), .y(y_c));

  ic_7400 #(.REGISTERED(1'b0), .TPD(5)) dut_d (
    .clk(clk), .rst(rst), .a(a_d), .b(b_d), .y(y_d));

  ic_7400 #(.REGISTERED(1'b1), .TPD(0), .RESET_VALUE(4'b1111)) dut_r (
    .clk(clk), .rst(rst), .a(a_r), .b(b_r), .y(y_r));

  function automatic logic [3:0] ref_nand(input logic [3:0] x, input logic [3:0] z);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] ra, rb, exp_r;
    logic       rrst;

    // Combinational instance
    a_c = 4'b0000; b_c = 4'b0000; #1;
    check("comb_zero", y_c, 4'b1111);
    a_c = 4'b0001; b_c = 4'b0001; #1;
    check("comb_step1", y_c, 4'b1110);
    a_c = 4'b0011; b_c = 4'b0011; #1;
    check("comb_step2", y_c, 4'b1100);
    a_c = 4'b0111; b_c = 4'b0111; #1;
    check("comb_step3", y_c, 4'b1000);
    a_c = 4'b1111; b_c = 4'b1111; #1;
    check("comb_step4", y_c, 4'b0000);
    a_c = 4'b1010; b_c = 4'b0110; #1;
    check("comb_mixed", y_c, 4'b1101);
    rst = 1'b1; #1;
    check("comb_rst_ignored", y_c, 4'b1101);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      a_c = ra; b_c = rb; #1;
      check("comb_rand", y_c, ref_nand(ra, rb));
    end

    // Delayed instance: y[0] rises exactly TPD=5 after the input change
    a_d = 4'b0001; b_d = 4'b0001; #10;
    check("tpd_settled", y_d, 4'b1110);
    a_d = 4'b0000; b_d = 4'b0000;
    #4;
    check("tpd_before", {3'b000, y_d[0]}, 4'b0000);
    #2;
    check("tpd_after", {3'b000, y_d[0]}, 4'b0001);

    // Registered instance: inputs driven on the falling edge
    @(negedge clk);
    rst = 1'b1; a_r = 4'b1111; b_r = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reg_reset", y_r, 4'b1111);
    @(negedge clk);
    rst = 1'b0; #1;
    check("reg_release_hold", y_r, 4'b1111);
    @(posedge clk); #1;
    check("reg_release_edge", y_r, 4'b0000);
    @(negedge clk);
    a_r = 4'b0000; b_r = 4'b0000;
    @(posedge clk); #1;
    check("reg_zero", y_r, 4'b1111);
    #2;
    a_r = 4'b0011; b_r = 4'b0011; #1;
    check("reg_midcycle_hold", y_r, 4'b1111);
    @(posedge clk); #1;
    check("reg_midcycle_edge", y_r, 4'b1100);
    @(negedge clk);
    rst = 1'b1; a_r = 4'b1111; b_r = 4'b1111;
    @(posedge clk); #1;
    check("reg_mid_reset", y_r, 4'b1111);

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      rrst = ($urandom_range(0, 7) == 0);
      a_r = ra; b_r = rb; rst = rrst;
      exp_r = rrst ? 4'b1111 : ref_nand(ra, rb);
      @(posedge clk); #1;
      check("reg_rand", y_r, exp_r);
      #2;
      a_r = ~ra; b_r = 4'($urandom); #1;
      check("reg_rand_hold", y_r, exp_r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
